sram_arbiter: RTL and testbench

Owns the single external asynchronous SRAM (ADR/DAT/RAMCS_b/RAMOE_b/RAMWE_b) and shares it among three requesters: the SPI boot loader, the video fetch unit, and the 6502 CPU port. Each request is served as one fixed-length SRAM cycle. The boot loader has absolute priority. Video and CPU alternate round-robin when both are pending. The block sits between the requesters and the top-level pads; the top level performs the DAT tri-state from `sram_dat_o`/`sram_dat_oe`.

---
 rtl/sram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM among the SPI boot loader, video fetch and the CPU port.
// Boot has absolute priority; video and CPU alternate round-robin when both are pending.
module sram_arbiter #(
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              boot_req,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [7:0]        boot_wdata,
    output logic              boot_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        rdata,
    output logic [2:0]        gnt,
    output logic [ADDR_W-1:0] ADR,
    output logic [7:0]        sram_dat_o,
    output logic              sram_dat_oe,
    input  logic [7:0]        sram_dat_i,
    output logic              RAMCS_b,
    output logic              RAMOE_b,
    output logic              RAMWE_b
);
    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    localparam logic [1:0] CntLoad = 2'(STROBE_CYCLES - 1);

    state_e            r_state, w_state_d;
    logic [1:0]        r_cnt, w_cnt_d;
    logic              r_last_vid;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_we;
    logic [2:0]        r_gnt, r_ack;
    logic [7:0]        r_rdata;
    logic              r_cs_b, r_oe_b, r_we_b, r_dat_oe;

    logic [2:0]        w_elig, w_win;
    logic              w_grant, w_win_we, w_last_cnt;
    logic [ADDR_W-1:0] w_win_addr;
    logic [7:0]        w_win_wdata;
    logic [2:0]        w_gnt_d, w_ack_d;
    logic              w_we_d, w_cs_b_d, w_oe_b_d, w_we_b_d, w_dat_oe_d;

    assign w_last_cnt = (r_cnt == 2'd0);

    // Arbitration; the owner being acked in HOLD may not win again that cycle.
    always_comb begin
        w_elig = {cpu_req, vid_req, boot_req};
        if (r_state == StHold) begin
            w_elig = w_elig & ~r_gnt;
        end
        w_win = 3'b000;
        if (r_state == StIdle || r_state == StHold) begin
            if (w_elig[0]) begin
                w_win = 3'b001;
            end else if (w_elig[1] && w_elig[2]) begin
                w_win = r_last_vid ? 3'b100 : 3'b010;
            end else if (w_elig[1]) begin
                w_win = 3'b010;
            end else if (w_elig[2]) begin
                w_win = 3'b100;
            end
        end
        w_grant     = |w_win;
        w_win_addr  = cpu_addr;
        w_win_wdata = cpu_wdata;
        w_win_we    = cpu_we;
        if (w_win[0]) begin
            w_win_addr  = boot_addr;
            w_win_wdata = boot_wdata;
            w_win_we    = 1'b1;
        end else if (w_win[1]) begin
            w_win_addr  = vid_addr;
            w_win_we    = 1'b0;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_grant) w_state_d = StSetup;
            end
            StSetup: begin
                w_state_d = StStrobe;
                w_cnt_d   = CntLoad;
            end
            StStrobe: begin
                if (w_last_cnt) w_state_d = StHold;
                else            w_cnt_d   = r_cnt - 2'd1;
            end
            StHold: begin
                w_state_d = w_grant ? StSetup : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every pad is driven straight from a flop.
    always_comb begin
        w_we_d     = w_grant ? w_win_we : r_we;
        w_gnt_d    = w_grant ? w_win : r_gnt;
        w_cs_b_d   = 1'b1;
        w_oe_b_d   = 1'b1;
        w_we_b_d   = 1'b1;
        w_dat_oe_d = 1'b0;
        w_ack_d    = 3'b000;
        case (w_state_d)
            StIdle: begin
                w_gnt_d = 3'b000;
            end
            StSetup: begin
                w_cs_b_d   = 1'b0;
                w_oe_b_d   = w_we_d;
                w_dat_oe_d = w_we_d;
            end
            StStrobe: begin
                w_cs_b_d   = 1'b0;
                w_oe_b_d   = w_we_d;
                w_we_b_d   = ~w_we_d;
                w_dat_oe_d = w_we_d;
            end
            StHold: begin
                w_cs_b_d   = 1'b0;
                w_dat_oe_d = w_we_d;
                w_ack_d    = w_gnt_d;
            end
            default: begin
                w_gnt_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= 2'd0;
            r_last_vid <= 1'b0;
            r_we       <= 1'b0;
            r_gnt      <= 3'b000;
            r_ack      <= 3'b000;
            r_rdata    <= 8'h00;
            r_cs_b     <= 1'b1;
            r_oe_b     <= 1'b1;
            r_we_b     <= 1'b1;
            r_dat_oe   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_we     <= w_we_d;
            r_gnt    <= w_gnt_d;
            r_ack    <= w_ack_d;
            r_cs_b   <= w_cs_b_d;
            r_oe_b   <= w_oe_b_d;
            r_we_b   <= w_we_b_d;
            r_dat_oe <= w_dat_oe_d;
            if (w_grant && w_win[1]) begin
                r_last_vid <= 1'b1;
            end else if (w_grant && w_win[2]) begin
                r_last_vid <= 1'b0;
            end
            if (r_state == StStrobe && w_last_cnt && !r_we) begin
                r_rdata <= sram_dat_i;
            end
        end
    end

    // Address and write data survive reset so WE_b rises on a stable bus.
    always_ff @(posedge clk25) begin
        if (w_grant && !reset) begin
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
        end
    end

    assign boot_ack    = r_ack[0];
    assign vid_ack     = r_ack[1];
    assign cpu_ack     = r_ack[2];
    assign gnt         = r_gnt;
    assign rdata       = r_rdata;
    assign ADR         = r_addr;
    assign sram_dat_o  = r_wdata;
    assign sram_dat_oe = r_dat_oe;
    assign RAMCS_b     = r_cs_b;
    assign RAMOE_b     = r_oe_b;
    assign RAMWE_b     = r_we_b;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: two instances (STROBE_CYCLES 1 and 3), each with
// a behavioural asynchronous SRAM; table-driven single accesses plus multi-cycle sequences.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #20 clk = ~clk;

    // Instance 0 (S=1)
    logic        boot_req = 0, vid_req = 0, cpu_req = 0, cpu_we = 0;
    logic [17:0] boot_addr = 0, vid_addr = 0, cpu_addr = 0;
    logic [7:0]  boot_wdata = 0, cpu_wdata = 0;
    logic        boot_ack, vid_ack, cpu_ack;
    logic [7:0]  rdata, sram_dat_o, sram_dat_i;
    logic [2:0]  gnt;
    logic [17:0] ADR;
    logic        sram_dat_oe, RAMCS_b, RAMOE_b, RAMWE_b;

    // Instance 1 (S=3)
    logic        b3_req = 0, v3_req = 0, c3_req = 0, c3_we = 0;
    logic [17:0] b3_addr = 0, v3_addr = 0, c3_addr = 0;
    logic [7:0]  b3_wdata = 0, c3_wdata = 0;
    logic        b3_ack, v3_ack, c3_ack;
    logic [7:0]  rdata3, dat_o3, dat_i3;
    logic [2:0]  gnt3;
    logic [17:0] adr3;
    logic        dat_oe3, cs3_b, oe3_b, we3_b;

    sram_arbiter #(.ADDR_W(18), .STROBE_CYCLES(1)) dut (
        .clk25(clk), .reset(reset),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_ack(boot_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .rdata(rdata), .gnt(gnt), .ADR(ADR), .sram_dat_o(sram_dat_o),
        .sram_dat_oe(sram_dat_oe), .sram_dat_i(sram_dat_i),
        .RAMCS_b(RAMCS_b), .RAMOE_b(RAMOE_b), .RAMWE_b(RAMWE_b)
    );

    sram_arbiter #(.ADDR_W(18), .STROBE_CYCLES(3)) dut3 (
        .clk25(clk), .reset(reset),
        .boot_req(b3_req), .boot_addr(b3_addr), .boot_wdata(b3_wdata), .boot_ack(b3_ack),
        .vid_req(v3_req), .vid_addr(v3_addr), .vid_ack(v3_ack),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_ack(c3_ack), .rdata(rdata3), .gnt(gnt3), .ADR(adr3), .sram_dat_o(dat_o3),
        .sram_dat_oe(dat_oe3), .sram_dat_i(dat_i3),
        .RAMCS_b(cs3_b), .RAMOE_b(oe3_b), .RAMWE_b(we3_b)
    );

    // Behavioural SRAMs: write latched on WE_b rising, read while CS_b and OE_b are low.
    logic [7:0] mem  [0:262143];
    logic [7:0] mem3 [0:262143];
    always @(posedge RAMWE_b) if (RAMCS_b === 1'b0) mem[ADR] <= sram_dat_o;
    always @(posedge we3_b)   if (cs3_b === 1'b0)   mem3[adr3] <= dat_o3;
    assign sram_dat_i = (RAMCS_b === 1'b0 && RAMOE_b === 1'b0) ? mem[ADR] : 8'h00;
    assign dat_i3     = (cs3_b === 1'b0 && oe3_b === 1'b0) ? mem3[adr3] : 8'h00;

    int          sel = 0;
    logic [2:0]  m_ack, m_gnt;
    logic [7:0]  m_rdata;
    logic [17:0] m_adr;
    logic        m_we_b;
    always_comb begin
        if (sel == 0) begin
            m_ack = {cpu_ack, vid_ack, boot_ack}; m_gnt = gnt; m_rdata = rdata;
            m_adr = ADR; m_we_b = RAMWE_b;
        end else begin
            m_ack = {c3_ack, v3_ack, b3_ack}; m_gnt = gnt3; m_rdata = rdata3;
            m_adr = adr3; m_we_b = we3_b;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // who: 0 boot, 1 vid, 2 cpu; cpu_we is set opposite to the access type for vid/boot.
    task automatic drive_req(input int inst, input int who, input logic r, input logic we,
                             input logic [17:0] a, input logic [7:0] d);
        if (inst == 0) begin
            case (who)
                0:       begin boot_req = r; boot_addr = a; boot_wdata = d; cpu_we = 1'b0; end
                1:       begin vid_req = r; vid_addr = a; cpu_we = 1'b1; end
                default: begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
            endcase
        end else begin
            case (who)
                0:       begin b3_req = r; b3_addr = a; b3_wdata = d; c3_we = 1'b0; end
                1:       begin v3_req = r; v3_addr = a; c3_we = 1'b1; end
                default: begin c3_req = r; c3_we = we; c3_addr = a; c3_wdata = d; end
            endcase
        end
    endtask

    task automatic access(input int inst, input int who, input logic we, input logic [17:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        int          cyc;
        int          we_low;
        int          s_cyc;
        logic        adr_ok;
        logic [17:0] adr0;
        logic [2:0]  who_oh;
        s_cyc  = (inst == 0) ? 1 : 3;
        who_oh = 3'b001 << who;
        sel    = inst;
        drive_req(inst, who, 1'b1, we, addr, wd);
        cyc = 0; we_low = 0; adr_ok = 1'b1; adr0 = '0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m_we_b == 1'b0) we_low++;
            if (cyc == 1) begin
                check("gnt_in_setup", {29'd0, m_gnt}, {29'd0, who_oh});
                adr0 = m_adr;
            end else if (m_adr !== adr0) begin
                adr_ok = 1'b0;
            end
            if (m_ack != 3'b000) break;
        end
        check("ack_latency", cyc, 2 + s_cyc);
        check("ack_owner", {29'd0, m_ack}, {29'd0, who_oh});
        check("adr_value", {14'd0, adr0}, {14'd0, addr});
        check("adr_stable", {31'd0, adr_ok}, 32'd1);
        check("we_low_cycles", we_low, we ? s_cyc : 0);
        drive_req(inst, who, 1'b0, we, addr, wd);
        if (we) begin
            check("mem_written", {24'd0, (inst == 0) ? mem[addr] : mem3[addr]}, {24'd0, wd});
        end else begin
            check("rdata_at_ack", {24'd0, m_rdata}, {24'd0, exp_rd});
        end
        @(negedge clk);
        if (!we) check("rdata_held", {24'd0, m_rdata}, {24'd0, exp_rd});
    endtask

    task automatic wait_ack(output logic [2:0] a, output int gap);
        gap = 0; a = 3'b000;
        while (gap < 20 && a == 3'b000) begin
            @(negedge clk);
            gap++;
            a = m_ack;
        end
    endtask

    typedef struct {
        int          inst;
        int          who;
        logic        we;
        logic [17:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [2:0] a;
        int         gap;
        logic       any_ack;

        vecs[0]  = '{0, 0, 1'b1, 18'h0C000, 8'hA5, 8'h00};
        vecs[1]  = '{0, 2, 1'b0, 18'h08000, 8'h00, 8'h3C};
        vecs[2]  = '{0, 2, 1'b1, 18'h00123, 8'h5A, 8'h00};
        vecs[3]  = '{0, 1, 1'b0, 18'h00123, 8'h00, 8'h5A};
        vecs[4]  = '{0, 2, 1'b0, 18'h0C000, 8'h00, 8'hA5};
        vecs[5]  = '{0, 0, 1'b1, 18'h3FFFF, 8'hFF, 8'h00};
        vecs[6]  = '{0, 1, 1'b0, 18'h3FFFF, 8'h00, 8'hFF};
        vecs[7]  = '{0, 2, 1'b0, 18'h00000, 8'h00, 8'h00};
        vecs[8]  = '{1, 0, 1'b1, 18'h0C000, 8'hA5, 8'h00};
        vecs[9]  = '{1, 2, 1'b0, 18'h0C000, 8'h00, 8'hA5};
        vecs[10] = '{1, 2, 1'b1, 18'h00042, 8'hC3, 8'h00};
        vecs[11] = '{1, 1, 1'b0, 18'h00042, 8'h00, 8'hC3};

        mem[18'h08000] = 8'h3C;
        mem[18'h00000] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_acks", {29'd0, cpu_ack, vid_ack, boot_ack}, 32'd0);
        check("rst_strobes", {29'd0, RAMCS_b, RAMOE_b, RAMWE_b}, 32'h7);
        check("rst_dat_oe", {31'd0, sram_dat_oe}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_strobes_s3", {29'd0, cs3_b, oe3_b, we3_b}, 32'h7);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            access(vecs[i].inst, vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rd);
        end

        // vid and cpu both held from reset: vid first, then strict alternation, no gaps.
        sel = 0;
        reset = 1'b1;
        vid_req = 1'b1; vid_addr = 18'h00123;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h08000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(a, gap);
            check("rr_gap", gap, 3);
            check("rr_owner", {29'd0, a}, (k % 2 == 0) ? 32'h2 : 32'h4);
            check("rr_rdata", {24'd0, rdata}, (k % 2 == 0) ? 32'h5A : 32'h3C);
        end

        // Boot arrives during a cpu HOLD and takes the next slot.
        boot_req = 1'b1; boot_addr = 18'h00200; boot_wdata = 8'h99; cpu_we = 1'b0;
        wait_ack(a, gap);
        check("boot_gap", gap, 3);
        check("boot_owner", {29'd0, a}, 32'h1);
        check("boot_mem", {24'd0, mem[18'h00200]}, 32'h99);
        boot_req = 1'b0;
        wait_ack(a, gap);
        check("resume_gap", gap, 3);
        check("resume_vid", {29'd0, a}, 32'h2);
        wait_ack(a, gap);
        check("resume_cpu", {29'd0, a}, 32'h4);
        cpu_req = 1'b0;
        wait_ack(a, gap);
        check("drain_vid", {29'd0, a}, 32'h2);
        vid_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset pulsed during the STROBE of a cpu write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h01234; cpu_wdata = 8'h77;
        repeat (2) @(negedge clk);
        check("abort_in_strobe", {31'd0, RAMWE_b}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_strobes", {29'd0, RAMCS_b, RAMOE_b, RAMWE_b}, 32'h7);
        check("abort_dat_oe", {31'd0, sram_dat_oe}, 32'd0);
        check("abort_adr", {14'd0, ADR}, 32'h01234);
        check("abort_gnt", {29'd0, gnt}, 32'd0);
        reset = 1'b0;
        cpu_req = 1'b0;
        any_ack = cpu_ack;
        repeat (4) begin
            @(negedge clk);
            any_ack = any_ack | cpu_ack | vid_ack | boot_ack;
        end
        check("abort_no_ack", {31'd0, any_ack}, 32'd0);
        access(0, 2, 1'b0, 18'h08000, 8'h00, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
